// File: rtl/uart_tx_buffer_pkg.sv
// uart_tx_buffer_pkg: shared types for the UART transmit buffer.
// Byte width and sequencer state encoding.
package uart_tx_buffer_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// uart_tx_buffer_if: host byte write channel.
// valid/ready handshake, master drives bytes.
interface uart_tx_buffer_if;
    import uart_tx_buffer_pkg::*;

    logic  wr_valid;
    byte_t wr_data;
    logic  wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/uart_tx_buffer_sync_fifo.sv
// sync_fifo: byte storage with wrapping pointers.
// level is an up/down counter, not a pointer difference.
module sync_fifo
    import uart_tx_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = UART_DATA_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [ADDR_W:0]  o_level,
    output logic             o_empty,
    output logic             o_full
);

    localparam logic [ADDR_W:0] LP_FULL = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;

    logic w_wr;
    logic w_rd;

    assign o_full    = (r_level == LP_FULL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_wr = i_wr_en && !o_full && !i_flush;
    assign w_rd = i_rd_en && !o_empty && !i_flush;

    // Storage: write the incoming byte at the tail.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; flush empties the queue.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= '0;
        end else if (i_flush) begin
            r_level <= '0;
        end else begin
            unique case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte queue plus send sequencer that
// feeds the UART transmitter one frame at a time.
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    uart_tx_buffer_if.slave        host,
    input  logic                   flush,
    input  logic                   tx_active_flag,
    input  logic                   tx_done_flag,
    output logic                   send,
    output logic [UART_DATA_W-1:0] data_in,
    output logic [ADDR_W:0]        level,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic                   busy
);

    tx_state_e r_state;
    logic      r_send;
    byte_t     r_data;
    logic      r_overflow;

    byte_t           w_rd_data;
    logic [ADDR_W:0] w_level;
    logic            w_empty;
    logic            w_full;
    logic            w_wr_en;
    logic            w_pop;

    // A flush on the same edge discards the write.
    assign w_wr_en = host.wr_valid && !w_full && !flush;

    // Only an idle sequencer takes the head byte.
    assign w_pop = (r_state == ST_IDLE) && !w_empty && !flush;

    // Held low during reset so the host cannot write into it.
    assign host.wr_ready = reset_n && !w_full;

    assign send     = r_send;
    assign data_in  = r_data;
    assign level    = w_level;
    assign empty    = w_empty;
    assign full     = w_full;
    assign overflow = r_overflow;
    assign busy     = (r_state != ST_IDLE);

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (UART_DATA_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_flush   (flush),
        .i_wr_en   (w_wr_en),
        .i_wr_data (host.wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_level   (w_level),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    // Sticky flag for a write offered while full.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_overflow <= 1'b0;
        end else if (host.wr_valid && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Sequencer: pop, hold send until the frame starts, await done.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_send  <= 1'b0;
            r_data  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_send <= 1'b0;
                    if (w_pop) begin
                        r_data  <= w_rd_data;
                        r_state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (tx_done_flag) begin
                        r_send  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (tx_active_flag) begin
                        r_send  <= 1'b0;
                        r_state <= ST_WAIT_DONE;
                    end else begin
                        r_send  <= 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    r_send <= 1'b0;
                    if (tx_done_flag) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_send  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed bench with a byte scoreboard
// and a simple transmitter model closing the send loop.
module tb_uart_tx_buffer;
    import uart_tx_buffer_pkg::*;

    localparam int FRAME = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       tx_active_flag;
    logic       tx_done_flag;
    logic       send;
    logic [7:0] data_in;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       busy;

    uart_tx_buffer_if bus ();

    uart_tx_buffer #(
        .DEPTH  (16),
        .ADDR_W (4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .host           (bus),
        .flush          (flush),
        .tx_active_flag (tx_active_flag),
        .tx_done_flag   (tx_done_flag),
        .send           (send),
        .data_in        (data_in),
        .level          (level),
        .empty          (empty),
        .full           (full),
        .overflow       (overflow),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   rises    = 0;
    int   rx_count = 0;
    logic tx_en    = 1'b0;
    logic hold_done = 1'b0;
    logic [7:0] sb [$];

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // Count rising edges of send.
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clock);
            if (send === 1'b1 && prev !== 1'b1) rises++;
            prev = send;
        end
    end

    // Transmitter model: captures data_in on send and compares it.
    initial begin
        int cnt = 0;
        logic [7:0] exp_b;
        tx_active_flag = 1'b0;
        tx_done_flag   = 1'b0;
        forever begin
            @(negedge clock);
            tx_done_flag = 1'b0;
            if (reset_n !== 1'b1) begin
                tx_active_flag = 1'b0;
                cnt = 0;
            end else if (tx_active_flag) begin
                if (cnt < FRAME) begin
                    cnt++;
                end else if (!hold_done) begin
                    tx_active_flag = 1'b0;
                    tx_done_flag   = 1'b1;
                end
            end else if (tx_en && send === 1'b1) begin
                n_checks++;
                assert (sb.size() > 0) else begin
                    n_fail++;
                    $error("FAIL tx_unexpected: observed %02h expected none",
                           data_in);
                end
                if (sb.size() > 0) begin
                    exp_b = sb.pop_front();
                    check("tx_byte", data_in, exp_b);
                end
                rx_count++;
                tx_active_flag = 1'b1;
                cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wr_once(input logic [7:0] d,
                           input logic exp_ready,
                           input string tag);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        check(tag, bus.wr_ready, exp_ready);
        if (exp_ready) sb.push_back(d);
        @(negedge clock);
        bus.wr_valid = 1'b0;
    endtask

    task automatic hs_write(input logic [7:0] d);
        int t = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        while (bus.wr_ready !== 1'b1 && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("wr_wait", t < 200, 1);
        if (t < 200) sb.push_back(d);
        @(negedge clock);
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int t = 0;
        while (!(busy === 1'b0 && empty === 1'b1) && t < limit) begin
            @(negedge clock);
            t++;
        end
        check(tag, t < limit, 1);
    endtask

    initial begin
        int r0;
        int c0;
        int t;
        reset_n      = 1'b0;
        flush        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        repeat (2) @(negedge clock);
        check("rst_send", send, 0);
        check("rst_data", data_in, 8'h00);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", bus.wr_ready, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // T1: async reset while in LAUNCH with three queued
        tx_en = 1'b0;
        wr_once(8'h11, 1, "t1_ready");
        wr_once(8'h22, 1, "t1_ready");
        wr_once(8'h33, 1, "t1_ready");
        wr_once(8'h44, 1, "t1_ready");
        check("t1_level", level, 3);
        check("t1_send", send, 1);
        check("t1_data", data_in, 8'h11);
        #2 reset_n = 1'b0;
        #1;
        check("t1_rst_send", send, 0);
        check("t1_rst_level", level, 0);
        check("t1_rst_empty", empty, 1);
        check("t1_rst_data", data_in, 8'h00);
        check("t1_rst_busy", busy, 0);
        check("t1_rst_ready", bus.wr_ready, 0);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // T2: single byte latency
        tx_en = 1'b1;
        wr_once(8'hA5, 1, "t2_ready");
        check("t2_level", level, 1);
        check("t2_empty", empty, 0);
        check("t2_send_n", send, 0);
        @(negedge clock);
        check("t2_send_n1", send, 0);
        check("t2_busy", busy, 1);
        @(negedge clock);
        check("t2_send_n2", send, 1);
        check("t2_data_n2", data_in, 8'hA5);
        @(negedge clock);
        check("t2_send_drop", send, 0);
        wait_idle("t2_idle", 100);
        check("t2_busy_end", busy, 0);

        // T3: 16-byte burst
        r0 = rises;
        c0 = rx_count;
        for (int i = 1; i <= 16; i++) hs_write(8'(i));
        wait_idle("t3_idle", 2000);
        check("t3_rises", rises - r0, 16);
        check("t3_rx", rx_count - c0, 16);
        check("t3_sb", sb.size(), 0);

        // T4: overflow with the transmitter stalled
        tx_en = 1'b0;
        for (int i = 0; i < 17; i++) wr_once(8'(8'h30 + i), 1, "t4_ready");
        check("t4_level", level, 16);
        check("t4_full", full, 1);
        wr_once(8'hFF, 0, "t4_ready_full");
        check("t4_ovf", overflow, 1);
        check("t4_level_ovf", level, 16);
        tx_en = 1'b1;
        wait_idle("t4_idle", 2000);
        check("t4_sb", sb.size(), 0);
        check("t4_ovf_sticky", overflow, 1);

        // T5: write coinciding with an IDLE pop
        hold_done = 1'b1;
        for (int i = 0; i < 6; i++) hs_write(8'(8'h50 + i));
        repeat (6) @(negedge clock);
        check("t5_level", level, 5);
        hold_done = 1'b0;
        t = 0;
        while (busy !== 1'b0 && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("t5_wait", t < 100, 1);
        wr_once(8'h56, 1, "t5_ready");
        check("t5_simul_level", level, 5);
        wait_idle("t5_idle", 2000);
        check("t5_sb", sb.size(), 0);

        // T5 wrap: 40 bytes through the 16-entry queue
        c0 = rx_count;
        for (int i = 0; i < 40; i++) hs_write(8'(8'h80 + i));
        wait_idle("t5w_idle", 4000);
        check("t5w_rx", rx_count - c0, 40);
        check("t5w_sb", sb.size(), 0);

        // T6: flush while a frame is in flight
        hold_done = 1'b1;
        for (int i = 0; i < 5; i++) hs_write(8'(8'h60 + i));
        repeat (8) @(negedge clock);
        check("t6_level", level, 4);
        check("t6_busy", busy, 1);
        flush        = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hEE;
        @(negedge clock);
        flush        = 1'b0;
        bus.wr_valid = 1'b0;
        check("t6_flush_level", level, 0);
        check("t6_flush_empty", empty, 1);
        check("t6_flush_ovf", overflow, 0);
        check("t6_flush_busy", busy, 1);
        check("t6_flush_data", data_in, 8'h60);
        sb.delete();
        r0 = rises;
        c0 = rx_count;
        hold_done = 1'b0;
        wait_idle("t6_idle", 200);
        repeat (20) @(negedge clock);
        check("t6_rises", rises - r0, 0);
        check("t6_rx", rx_count - c0, 0);
        check("t6_level_end", level, 0);
        check("t6_busy_end", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
